// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: debounced start/stop and clear buttons driving an IDLE/RUN/PAUSE tick generator
module stopwatch_timebase #(
  parameter int DIVISOR        = 500000,
  parameter int DIV_BITS       = 19,
  parameter int DEBOUNCE_COUNT = 250000,
  parameter int DB_BITS        = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic start_stop_n,
  input  logic clear_n,
  output logic tick,
  output logic running,
  output logic counter_clr_n
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, s1_d, s2_q, s2_d, db_q, db_d, last_q, last_d, press;
  logic [1:0][DB_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic tick_q, tick_d, running_q, running_d, clr_n_q, clr_n_d;
  logic ss, cl, wrap;
  always_comb begin
    s1_d = {start_stop_n, clear_n};
    s2_d = s1_q;
    last_d = db_q;
    db_d = db_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_BITS'(DEBOUNCE_COUNT)) db_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  // bit 1 is start/stop, bit 0 is clear; only falling debounced edges are events
  assign press = last_q & ~db_q;
  assign ss = press[1];
  assign cl = press[0];
  assign wrap = pre_q == DIV_BITS'(DIVISOR - 1);
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    tick_d = 1'b0;
    clr_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (cl) begin
          clr_n_d = 1'b0;
          pre_d = '0;
        end else if (ss) state_d = RUN;
      end
      RUN: begin
        pre_d = wrap ? '0 : pre_q + 1'b1;
        tick_d = wrap & ~ss;
        if (ss) state_d = PAUSE;
      end
      PAUSE: begin
        if (cl) begin
          state_d = IDLE;
          clr_n_d = 1'b0;
          pre_d = '0;
        end else if (ss) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    running_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      db_q <= 2'b11;
      last_q <= 2'b11;
      cnt_q <= '0;
      state_q <= IDLE;
      pre_q <= '0;
      tick_q <= 1'b0;
      running_q <= 1'b0;
      clr_n_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      running_q <= running_d;
      clr_n_q <= clr_n_d;
    end
  end
  assign tick = tick_q;
  assign running = running_q;
  assign counter_clr_n = clr_n_q;
endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase: directed scenarios plus random button traffic against a reference model
module tb_stopwatch_timebase;
  localparam int DIV = 4;
  localparam int DBC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] pins = 2'b11;
  logic tick, running, counter_clr_n;
  int n_chk = 0, n_err = 0;

  stopwatch_timebase #(.DIVISOR(DIV), .DIV_BITS(2), .DEBOUNCE_COUNT(DBC), .DB_BITS(2)) dut (
    .clk(clk), .reset(reset), .start_stop_n(pins[1]), .clear_n(pins[0]),
    .tick(tick), .running(running), .counter_clr_n(counter_clr_n));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a button level is accepted once the pin sample seen two edges
  // late has disagreed with it for DBC+1 consecutive edges; an accepted press
  // acts one edge later. Ticks mark every DIV-th edge spent in RUN since the
  // last clear, except on the edge that leaves RUN.
  logic [1:0] hist[$];
  logic [1:0] m_lvl, m_evt;
  int m_diff[2];
  int m_mode, m_runs;
  logic m_tick, m_clrn;

  task automatic m_reset();
    hist = '{2'b11, 2'b11};
    m_lvl = 2'b11;
    m_evt = 2'b00;
    m_diff = '{0, 0};
    m_mode = M_IDLE;
    m_runs = 0;
    m_tick = 1'b0;
    m_clrn = 1'b1;
  endtask

  task automatic m_step();
    logic [1:0] del;
    logic ss, cl;
    ss = m_evt[1];
    cl = m_evt[0];
    m_tick = 1'b0;
    m_clrn = 1'b1;
    if (m_mode == M_RUN) begin
      m_runs++;
      m_tick = (m_runs % DIV == 0) && !ss;
      if (ss) m_mode = M_PAUSE;
    end else if (cl) begin
      m_mode = M_IDLE;
      m_clrn = 1'b0;
      m_runs = 0;
    end else if (ss) m_mode = M_RUN;
    m_evt = 2'b00;
    del = hist.pop_front();
    hist.push_back(pins);
    for (int i = 0; i < 2; i++) begin
      if (del[i] != m_lvl[i]) begin
        m_diff[i]++;
        if (m_diff[i] == DBC + 1) begin
          m_lvl[i] = del[i];
          m_diff[i] = 0;
          m_evt[i] = !del[i];
        end
      end else m_diff[i] = 0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    check("tick", tick, m_tick);
    check("running", running, m_mode == M_RUN);
    check("clr_n", counter_clr_n, m_clrn);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] m, input int n);
    pins = ~m;
    cyc(n);
    pins = 2'b11;
  endtask

  task automatic watch(input int n, output int t, output int c);
    t = 0;
    c = 0;
    repeat (n) begin
      @(negedge clk);
      t += int'(tick);
      c += int'(!counter_clr_n);
    end
    cyc(1);
  endtask

  initial begin
    int t, c, k;
    cyc(3);
    reset = 1'b1;
    // idle: nothing moves
    watch(50, t, c);
    check("idle_ticks", t, 0);
    check("idle_clr", c, 0);
    check("idle_running", running, 0);
    // start: running after 7 edges, first tick 4 edges later
    pins[1] = 1'b0;
    repeat (7) @(negedge clk);
    check("start_early", running, 0);
    @(negedge clk);
    check("start_run", running, 1);
    repeat (3) @(negedge clk);
    check("first_tick_early", tick, 0);
    @(negedge clk);
    check("first_tick", tick, 1);
    cyc(1);
    pins[1] = 1'b1;
    watch(40, t, c);
    check("tick_rate", t, 10);
    // short glitch is ignored
    hold(2'b10, 2);
    cyc(10);
    check("glitch_run", running, 1);
    // pause with prescaler at 2, resume ticks after 2 cycles
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < 20);
    check("tick_seen", tick, 1);
    cyc(3);
    hold(2'b10, 5);
    cyc(3);
    watch(12, t, c);
    check("pause_ticks", t, 0);
    check("pause_running", running, 0);
    pins[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("resume_run", running, 1);
    @(negedge clk);
    check("resume_tick_early", tick, 0);
    @(negedge clk);
    check("resume_tick", tick, 1);
    cyc(1);
    pins[1] = 1'b1;
    cyc(6);
    // clear in pause pulses once; clear in run is ignored
    hold(2'b10, 5);
    cyc(4);
    check("pause2", running, 0);
    hold(2'b01, 5);
    watch(15, t, c);
    check("pause_clr_pulses", c, 1);
    check("pause_clr_idle", running, 0);
    hold(2'b10, 5);
    cyc(4);
    check("rerun", running, 1);
    hold(2'b01, 5);
    watch(15, t, c);
    check("run_clr_pulses", c, 0);
    check("run_clr_running", running, 1);
    // both buttons in pause: clear wins
    hold(2'b10, 5);
    cyc(4);
    hold(2'b11, 5);
    watch(15, t, c);
    check("both_clr_pulses", c, 1);
    check("both_idle", running, 0);
    // async reset mid-run
    hold(2'b10, 5);
    cyc(6);
    check("pre_reset_run", running, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_tick", tick, 0);
    check("rst_running", running, 0);
    check("rst_clr", counter_clr_n, 1);
    cyc(2);
    reset = 1'b1;
    // random button traffic
    for (int i = 0; i < 150; i++) begin
      hold(2'($urandom_range(1, 3)), $urandom_range(1, 7));
      cyc($urandom_range(0, 12));
    end
    cyc(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
